iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
Multi-cycle parametrised shift/rotate unit for the datapath ALU. It executes logical right (SHR), arithmetic right (SHRA), left (SHL), rotate right (ROR) and rotate left (ROL). It shifts by up to STEP bit positions per clock under a Start/Busy/Done handshake. The ALU control sequencer launches it during the execute step and latches Result into Z when Done is high.

Parameters:
WIDTH, 32, operand and result width in bits
SHAMT_W, 5, shift-count width; must equal clog2(WIDTH)
STEP, 1, maximum bit positions shifted per cycle; power of two, 1..WIDTH

Ports:
Clock  input  1  system clock, rising-edge active
Clear  input  1  asynchronous active-high reset
Start  input  1  launch request, sampled on rising edge of Clock
Mode  input  3  operation: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 pass-through
A  input  WIDTH  operand to shift
Count  input  SHAMT_W  shift amount, 0..WIDTH-1
Busy  output  1  high while in SHIFT state
Done  output  1  one-cycle pulse when Result is valid
Result  output  WIDTH  registered result; holds until next completion

Behaviour:
- Reset: Clear=1 asynchronously forces state=IDLE, Busy=0, Done=0, Result=0, and clears the internal accumulator, remaining count and latched mode. This applies in any state, including mid-SHIFT. The aborted operation never produces Done.
- States: IDLE, SHIFT, DONE.
- IDLE: Start=1 at an edge latches acc<=A, rem<=Count, mode<=Mode.
  - If Count=0: go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT: each edge shifts acc by k=min(STEP, rem) positions and sets rem<=rem-k.
  - SHR fills with 0 from the MSB side.
  - SHRA replicates the latched MSB of acc.
  - SHL fills with 0 from the LSB side.
  - ROR/ROL wrap bits around.
  - Pass-through modes leave acc unchanged but still consume cycles.
  - When rem becomes 0 at that edge, go to DONE.
- DONE: Result<=acc is loaded on the transition into DONE, so it is visible during the DONE cycle. Done=1 for exactly one cycle.
  - Start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
  - Otherwise go to IDLE.
- Latency: with Start sampled at edge 0, Done is high after edge ceil(Count/STEP)+1. Count=0 gives Done after edge 1.
- Busy=1 only in SHIFT; Done=1 only in DONE; Busy and Done are never both high.
- Start while in SHIFT is ignored. A and Count may change freely after the launch edge with no effect.
- Result changes only on entry to DONE or on Clear. It holds its value through IDLE and SHIFT.
- Shifts never exceed WIDTH-1 positions, so the Count width rules out overflow. The rotate amount is effectively modulo WIDTH.
- Fully synchronous except Clear. No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=32, STEP=1: Start with Mode=001, A=0xF0000012, Count=4 -> Busy high for 4 cycles, Done at edge 5, Result=0xFF000001.
2. Same A and Count with Mode=000 -> Result=0x0F000001. Mode=010 -> Result=0x00000120.
3. A=0x80000001, Count=1: Mode=100 -> 0x00000003. Mode=011 -> 0xC0000000. Mode=101 -> 0x80000001 with Done at edge 2.
4. Count=0, Mode=001, A=0x12345678 -> no Busy, Done at edge 1, Result=0x12345678. Then SHL A=0x1, Count=31 -> Result=0x80000000 with Done at edge 32 (STEP=1) or edge 9 (STEP=4).
5. Launch SHRA with Count=20. Pulse Clear after 3 SHIFT cycles -> Busy=0, Done=0 and Result=0 immediately, with no later Done. A new Start with Count=2, A=0x8 -> Result=0x2.
6. Pulse Start again during SHIFT -> ignored, and the original result is unchanged. Start high during the DONE cycle with A=0x10, Count=1, Mode=000 -> Result=0x8 two edges later.

Source files
------------

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: moves the operand up to STEP bit positions per clock.
// Start/Busy/Done handshake; Result is registered and held until the next completion.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               Start,
    input  logic [2:0]         Mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] Count,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Result
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W+1)'(WIDTH);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     acc, acc_sh, res_d;
    logic [SHAMT_W-1:0]   rem, rem_nxt, k;
    logic [SHAMT_W:0]     back_k;
    logic [2:0]           op;
    logic                 res_load;
    logic                 launch;

    // Final step may be shorter than STEP; rem never exceeds WIDTH-1, so k fits SHAMT_W.
    always_comb begin
        k       = ({1'b0, rem} < STEP_W) ? rem : STEP_W[SHAMT_W-1:0];
        rem_nxt = rem - k;
        back_k  = WIDTH_W - {1'b0, k};
        case (op)
            OP_SHR:  acc_sh = acc >> k;
            OP_SHRA: acc_sh = $signed(acc) >>> k;
            OP_SHL:  acc_sh = acc << k;
            OP_ROR:  acc_sh = (acc >> k) | (acc << back_k);
            OP_ROL:  acc_sh = (acc << k) | (acc >> back_k);
            default: acc_sh = acc;
        endcase
    end

    assign launch = Start && (state != SHIFT);

    always_comb begin
        state_nxt = state;
        res_load  = 1'b0;
        res_d     = acc_sh;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (Start) begin
                    if (Count == '0) begin
                        state_nxt = DONE;
                        res_load  = 1'b1;
                        res_d     = A;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (rem_nxt == '0) begin
                    state_nxt = DONE;
                    res_load  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            op     <= '0;
            Result <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                acc <= A;
                rem <= Count;
                op  <= Mode;
            end else if (state == SHIFT) begin
                acc <= acc_sh;
                rem <= rem_nxt;
            end
            if (res_load) Result <= res_d;
        end
    end

    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_iter_shift_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 1;

    logic               Clock = 1'b0;
    logic               Clear;
    logic               Start;
    logic [2:0]         Mode;
    logic [WIDTH-1:0]   A;
    logic [SHAMT_W-1:0] Count;
    logic               Busy, Done;
    logic [WIDTH-1:0]   Result;

    int checks = 0;
    int errors = 0;

    iter_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Mode(Mode), .A(A),
        .Count(Count), .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] a;
        logic [4:0]  cnt;
        logic [31:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: the operation done in one go with plain arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] m, input logic [31:0] a, input int n);
        logic [63:0] dbl;
        logic [31:0] fill;
        dbl  = {a, a};
        fill = a[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        case (m)
            3'd0:    return a >> n;
            3'd1:    return (a >> n) | fill;
            3'd2:    return a << n;
            3'd3:    return dbl[31:0] >> 0 == 0 ? 32'h0 : 32'((dbl >> n) & 64'hFFFF_FFFF);
            3'd4:    return 32'((dbl << n) >> 32);
            default: return a;
        endcase
    endfunction

    function automatic int ref_lat(input int n);
        return (n + STEP - 1) / STEP + 1;
    endfunction

    // Launch one op, scramble inputs afterwards, and report when Done appears
    // (lat = index of the edge at which Done is sampled, launch edge = 0).
    task automatic run_op(input logic [2:0] m, input logic [31:0] a, input logic [4:0] n,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge Clock);
        Start = 1'b1; Mode = m; A = a; Count = n;
        @(posedge Clock); #1;
        Start = 1'b0; A = $urandom; Count = 5'($urandom); Mode = 3'($urandom);
        lat = -1; busy_cnt = 0; res = '0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge Clock);
            if (Busy && Done) chk("busy_done_overlap", 32'(Busy & Done), 32'h0);
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = e; res = Result;
                break;
            end
        end
    endtask

    vec_t        vecs[8];
    logic [31:0] res;
    int          lat, bc, seen;
    logic [2:0]  rm;
    logic [31:0] ra;
    logic [4:0]  rn;

    initial begin
        vecs[0] = '{3'b001, 32'hF000_0012, 5'd4,  32'hFF00_0001};
        vecs[1] = '{3'b000, 32'hF000_0012, 5'd4,  32'h0F00_0001};
        vecs[2] = '{3'b010, 32'hF000_0012, 5'd4,  32'h0000_0120};
        vecs[3] = '{3'b100, 32'h8000_0001, 5'd1,  32'h0000_0003};
        vecs[4] = '{3'b011, 32'h8000_0001, 5'd1,  32'hC000_0000};
        vecs[5] = '{3'b101, 32'h8000_0001, 5'd1,  32'h8000_0001};
        vecs[6] = '{3'b001, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[7] = '{3'b010, 32'h0000_0001, 5'd31, 32'h8000_0000};

        Clear = 1'b1; Start = 1'b0; Mode = '0; A = '0; Count = '0;
        #12;
        chk("reset_busy", 32'(Busy), 32'h0);
        chk("reset_done", 32'(Done), 32'h0);
        chk("reset_result", Result, 32'h0);
        @(negedge Clock); Clear = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].cnt, res, lat, bc);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(ref_lat(int'(vecs[i].cnt))));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(ref_lat(int'(vecs[i].cnt)) - 1));
        end

        // Back-to-back: Start during the DONE cycle is accepted.
        run_op(3'b000, 32'h0000_0100, 5'd2, res, lat, bc);
        chk("b2b_first_result", res, 32'h0000_0040);
        Start = 1'b1; Mode = 3'b000; A = 32'h10; Count = 5'd1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(negedge Clock);
        chk("b2b_busy", 32'(Busy), 32'h1);
        chk("b2b_hold_result", Result, 32'h0000_0040);
        @(negedge Clock);
        chk("b2b_done", 32'(Done), 32'h1);
        chk("b2b_result", Result, 32'h0000_0008);

        // Start pulsed mid-SHIFT must be ignored.
        @(negedge Clock);
        Start = 1'b1; Mode = 3'b000; A = 32'hF000_0000; Count = 5'd8;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Start = 1'b1; Mode = 3'b010; A = 32'hFFFF_FFFF; Count = 5'd1;
        chk("shift_hold_result", Result, 32'h0000_0008);
        lat = -1; res = '0;
        for (int e = 3; e <= 30; e++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (Done) begin
                lat = e; res = Result;
                break;
            end
        end
        chk("ignore_start_result", res, 32'h00F0_0000);
        chk("ignore_start_latency", 32'(lat), 32'(ref_lat(8)));

        // Clear in the middle of SHIFT aborts without a Done.
        @(negedge Clock);
        Start = 1'b1; Mode = 3'b001; A = 32'h8000_0000; Count = 5'd20;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        chk("pre_clear_busy", 32'(Busy), 32'h1);
        Clear = 1'b1; #1;
        chk("clear_busy", 32'(Busy), 32'h0);
        chk("clear_done", 32'(Done), 32'h0);
        chk("clear_result", Result, 32'h0);
        @(negedge Clock); Clear = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge Clock);
            if (Done || Busy) seen++;
        end
        chk("no_done_after_clear", 32'(seen), 32'h0);
        run_op(3'b000, 32'h8, 5'd2, res, lat, bc);
        chk("after_clear_result", res, 32'h2);
        chk("after_clear_latency", 32'(lat), 32'(ref_lat(2)));

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rm = 3'($urandom_range(0, 7));
            ra = $urandom;
            rn = 5'($urandom_range(0, 31));
            run_op(rm, ra, rn, res, lat, bc);
            chk($sformatf("rand%0d_m%0d_n%0d_result", i, rm, rn), res, ref_op(rm, ra, int'(rn)));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(int'(rn))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
